// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, data word, arbiter FSM state
// and the access kinds the arbiter can grant.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {IDLE, SERVE} arb_state_t;

  typedef enum logic [1:0] {ACC_IREAD, ACC_DREAD, ACC_DWRITE} acc_t;

  // A core asserting dWEN and dREN together is treated as a write.
  function automatic acc_t pick_type(input logic ireq, input logic dreq, input logic wreq);
    if (wreq)      return ACC_DWRITE;
    else if (dreq) return ACC_DREAD;
    else           return ACC_IREAD;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational grant selection for two cores: preferred core first, then the
// other; within the chosen core, write beats data read beats instruction read.
module arb_select
  import cpu_types_pkg::*;
(
  input  logic [1:0] iren,
  input  logic [1:0] dren,
  input  logic [1:0] dwen,
  input  logic       pref,
  output logic       valid,
  output logic       core,
  output acc_t       acc
);

  logic [1:0] has_req;

  assign has_req = iren | dren | dwen;

  always_comb begin
    valid = |has_req;
    core  = has_req[pref] ? pref : ~pref;
    acc   = pick_type(iren[core], dren[core], dwen[core]);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core arbiter sharing one RAM port. Define MEM_ARBITER_RR_EN for
// round-robin between cores; otherwise core0 always has priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int WORDW  = $bits(word_t)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NCORES-1:0]              iREN,
  input  logic [NCORES-1:0]              dREN,
  input  logic [NCORES-1:0]              dWEN,
  input  logic [NCORES-1:0][WORDW-1:0]   iaddr,
  input  logic [NCORES-1:0][WORDW-1:0]   daddr,
  input  logic [NCORES-1:0][WORDW-1:0]   dstore,
  output logic [NCORES-1:0]              iwait,
  output logic [NCORES-1:0]              dwait,
  output logic [NCORES-1:0][WORDW-1:0]   iload,
  output logic [NCORES-1:0][WORDW-1:0]   dload,
  output logic [WORDW-1:0]               ramaddr,
  output logic [WORDW-1:0]               ramstore,
  output logic                           ramREN,
  output logic                           ramWEN,
  input  logic [WORDW-1:0]               ramload,
  input  ramstate_t                      ramstate
);

  arb_state_t state, next_state;
  logic       gnt_core;
  acc_t       gnt_acc;
  logic       pref;
  logic       sel_valid;
  logic       sel_core;
  acc_t       sel_acc;
  logic       live_req;
  logic       complete;

  arb_select u_select (
    .iren  (iREN),
    .dren  (dREN),
    .dwen  (dWEN),
    .pref  (pref),
    .valid (sel_valid),
    .core  (sel_core),
    .acc   (sel_acc)
  );

`ifdef MEM_ARBITER_RR_EN
  logic ptr;

  // After a completion the other core becomes preferred; aborts leave it alone.
  always_ff @(posedge CLK) begin
    if (RST)           ptr <= 1'b0;
    else if (complete) ptr <= ~gnt_core;
  end

  assign pref = ptr;
`else
  assign pref = 1'b0;
`endif

  always_comb begin
    case (gnt_acc)
      ACC_DWRITE: live_req = dWEN[gnt_core];
      ACC_DREAD:  live_req = dREN[gnt_core];
      default:    live_req = iREN[gnt_core];
    endcase
  end

  assign complete = (state == SERVE) && live_req && (ramstate == ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      gnt_core <= 1'b0;
      gnt_acc  <= ACC_IREAD;
    end else begin
      state <= next_state;
      if (state == IDLE && sel_valid) begin
        gnt_core <= sel_core;
        gnt_acc  <= sel_acc;
      end
    end
  end

  // A dropped request aborts the transaction even if RAM reports ACCESS.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_valid) next_state = SERVE;
      SERVE:   if (!live_req || complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (!RST && state == SERVE) begin
      case (gnt_acc)
        ACC_DWRITE: begin
          ramaddr  = daddr[gnt_core];
          ramstore = dstore[gnt_core];
          ramWEN   = dWEN[gnt_core];
          if (complete) dwait[gnt_core] = 1'b0;
        end
        ACC_DREAD: begin
          ramaddr = daddr[gnt_core];
          ramREN  = dREN[gnt_core];
          if (complete) begin
            dwait[gnt_core] = 1'b0;
            dload[gnt_core] = ramload;
          end
        end
        default: begin
          ramaddr = iaddr[gnt_core];
          ramREN  = iREN[gnt_core];
          if (complete) begin
            iwait[gnt_core] = 1'b0;
            iload[gnt_core] = ramload;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow
// MEM_ARBITER_RR_EN when it is defined for the build.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN;
  ramstate_t        ramstate;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .iaddr    (iaddr),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rst_en got %b%b expected 00", ramREN, ramWEN); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++; $display("FAIL rst_wait got %b/%b expected 11/11", iwait, dwait); end
    checks++; if (iload !== '0 || dload !== '0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rst_zero got %h/%h/%h expected 0", iload, dload, ramaddr); end
    RST = 1'b0;
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_idle_en got %b expected 0", ramREN); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL rst_serve got %b %h expected 1 00000040", ramREN, ramaddr); end
    RST = 1'b1;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL rst_during got %b %b expected 0 11", ramREN, iwait); end
    tick();
    tick();
    RST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rst_after_en got %b%b %h expected 00 0", ramREN, ramWEN, ramaddr); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++; $display("FAIL rst_after_wait got %b/%b expected 11/11", iwait, dwait); end
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = FREE;
    #1;
    checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL rd_idle got %b %b expected 11 0", iwait, ramREN); end
    tick();
    ramstate = BUSY;
    #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b11) begin errors++; $display("FAIL rd_c1 got %b %h %b expected 1 00000040 11", ramREN, ramaddr, iwait); end
    tick();
    checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL rd_c2 got %b expected 11", iwait); end
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL rd_iwait got %b expected 10", iwait); end
    checks++; if (iload[0] !== 32'hDEADBEEF || iload[1] !== 32'h0) begin errors++; $display("FAIL rd_iload got %h expected deadbeef_00000000", iload); end
    clear_inputs();
    tick();
    checks++; if (iwait !== 2'b11 || iload !== '0) begin errors++; $display("FAIL rd_after got %b %h expected 11 0", iwait, iload); end
  endtask

  task automatic test_type_priority();
    iREN = 2'b10; dWEN = 2'b10;
    iaddr[1] = 32'h100; daddr[1] = 32'h80; dstore[1] = 32'h12345678;
    tick();
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL pri_en got %b%b expected wen=1 ren=0", ramWEN, ramREN); end
    checks++; if (ramaddr !== 32'h80 || ramstore !== 32'h12345678) begin errors++; $display("FAIL pri_wr got %h %h expected 00000080 12345678", ramaddr, ramstore); end
    checks++; if (dwait !== 2'b01 || iwait !== 2'b11 || dload !== '0) begin errors++; $display("FAIL pri_wait got %b %b %h expected 01 11 0", dwait, iwait, dload); end
    dWEN = 2'b00;
    tick();
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL pri_gap got %b %b expected 0 11", ramREN, iwait); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL pri_rd got %b %h expected 1 00000100", ramREN, ramaddr); end
    checks++; if (iwait !== 2'b01 || iload[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL pri_rd_done got %b %h expected 01 cafef00d", iwait, iload[1]); end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_wait;
    logic [31:0] exp_addr;
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20;
    ramstate = ACCESS; ramload = 32'h55;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_wait = (RR && (k % 2 == 1)) ? 2'b01 : 2'b10;
      exp_addr = (RR && (k % 2 == 1)) ? 32'h20 : 32'h10;
      checks++; if (iwait !== exp_wait || ramaddr !== exp_addr) begin errors++; $display("FAIL rr_%0d got %b %h expected %b %h", k, iwait, ramaddr, exp_wait, exp_addr); end
      tick();
      checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL rr_gap_%0d got %b %b expected 11 0", k, iwait, ramREN); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_abort();
    dREN = 2'b01; daddr[0] = 32'h200; ramstate = ACCESS; ramload = 32'h11;
    tick();
    checks++; if (dwait !== 2'b10 || dload[0] !== 32'h11) begin errors++; $display("FAIL ab_pre got %b %h expected 10 00000011", dwait, dload[0]); end
    clear_inputs();
    tick();
    dREN = 2'b10; daddr[1] = 32'h300; ramstate = BUSY;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 2'b11) begin errors++; $display("FAIL ab_serve got %b %h %b expected 1 00000300 11", ramREN, ramaddr, dwait); end
    tick();
    dREN = 2'b00;
    #1;
    checks++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL ab_drop got %b %b expected 11 0", dwait, ramREN); end
    tick();
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20; ramstate = ACCESS;
    #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL ab_idle got %b %b expected 0 11", ramREN, dwait); end
    tick();
    exp_check_abort_ptr();
    clear_inputs();
    tick();
  endtask

  task automatic exp_check_abort_ptr();
    logic [1:0] exp_wait;
    exp_wait = RR ? 2'b01 : 2'b10;
    checks++; if (iwait !== exp_wait || dwait !== 2'b11) begin errors++; $display("FAIL ab_ptr got %b %b expected %b 11", iwait, dwait, exp_wait); end
  endtask

  task automatic test_error_hold();
    dWEN = 2'b01; daddr[0] = 32'h400; dstore[0] = 32'hA5A5A5A5;
    tick();
    ramstate = ERROR;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (dwait !== 2'b11 || ramWEN !== 1'b1 || ramstore !== 32'hA5A5A5A5) begin errors++; $display("FAIL err_%0d got %b %b %h expected 11 1 a5a5a5a5", k, dwait, ramWEN, ramstore); end
      tick();
    end
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 2'b10 || ramaddr !== 32'h400) begin errors++; $display("FAIL err_done got %b %h expected 10 00000400", dwait, ramaddr); end
    clear_inputs();
    tick();
    checks++; if (dwait !== 2'b11 || ramWEN !== 1'b0 || ramstore !== 32'h0) begin errors++; $display("FAIL err_after got %b %b %h expected 11 0 0", dwait, ramWEN, ramstore); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_type_priority();
    test_round_robin();
    test_abort();
    test_error_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
